video_proc_pipe: RTL

VIDEO_PROC_PIPE -- requirements
Module: video_proc_pipe

---
 rtl/video_proc_pipe.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_proc_pipe.sv
// Video processing pipeline: RGB565 in, bypass / gray / binary / blue-plate
// mask out, restricted to a rectangular ROI, with a per-frame white-pixel
// counter. Three register stages; syncs travel alongside the pixel data.
module video_proc_pipe #(
    parameter int H_W   = 11,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_hsync,
    input  logic             pre_frame_de,
    input  logic [15:0]      pre_rgb,
    input  logic [1:0]       mode,
    input  logic [7:0]       thresh,
    input  logic [H_W-1:0]   roi_x0,
    input  logic [H_W-1:0]   roi_x1,
    input  logic [H_W-1:0]   roi_y0,
    input  logic [H_W-1:0]   roi_y1,
    output logic             post_frame_vsync,
    output logic             post_frame_hsync,
    output logic             post_frame_de,
    output logic [15:0]      post_rgb,
    output logic [CNT_W-1:0] hit_count,
    output logic             hits_valid
);

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_BINARY = 2'd2,
        MODE_BLUE   = 2'd3
    } mode_e;

    localparam logic [H_W-1:0]   XY_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Frame/line edge detection and shadow settings
    // ------------------------------------------------------------------
    logic           vs_d, de_d;
    logic           vs_rise, de_fall;
    mode_e          sh_mode;
    logic [7:0]     sh_thresh;
    logic [H_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;

    assign vs_rise = pre_frame_vsync & ~vs_d;
    assign de_fall = de_d & ~pre_frame_de;

    // A pixel arriving together with vs_rise already sees the new settings.
    mode_e          eff_mode;
    logic [7:0]     eff_thresh;
    logic [H_W-1:0] eff_x0, eff_x1, eff_y0, eff_y1;

    assign eff_mode   = vs_rise ? mode_e'(mode) : sh_mode;
    assign eff_thresh = vs_rise ? thresh : sh_thresh;
    assign eff_x0     = vs_rise ? roi_x0 : sh_x0;
    assign eff_x1     = vs_rise ? roi_x1 : sh_x1;
    assign eff_y0     = vs_rise ? roi_y0 : sh_y0;
    assign eff_y1     = vs_rise ? roi_y1 : sh_y1;

    // Sync history and per-frame shadow copies of the control inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_d      <= 1'b0;
            de_d      <= 1'b0;
            sh_mode   <= MODE_BYPASS;
            sh_thresh <= '0;
            // Empty ROI until the first frame start after reset.
            sh_x0     <= XY_MAX;
            sh_x1     <= '0;
            sh_y0     <= XY_MAX;
            sh_y1     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            vs_d <= pre_frame_vsync;
            de_d <= pre_frame_de;
            if (vs_rise) begin
                sh_mode   <= eff_mode;
                sh_thresh <= eff_thresh;
                sh_x0     <= eff_x0;
                sh_x1     <= eff_x1;
                sh_y0     <= eff_y0;
                sh_y1     <= eff_y1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel coordinates
    // ------------------------------------------------------------------
    logic [H_W-1:0] x_cnt, y_cnt;
    logic [H_W-1:0] cur_x, cur_y;
    logic           in_roi;

    assign cur_x = vs_rise ? '0 : x_cnt;
    assign cur_y = vs_rise ? '0 : y_cnt;

    // Saturating x/y counters; x restarts after each line, y after each frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (pre_frame_de)
                x_cnt <= (cur_x == XY_MAX) ? XY_MAX : cur_x + H_W'(1);
            else if (de_fall || vs_rise)
                x_cnt <= '0;

            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && y_cnt != XY_MAX)
                y_cnt <= y_cnt + H_W'(1);
        end
    end

    assign in_roi = pre_frame_de &&
                    (cur_x >= eff_x0) && (cur_x <= eff_x1) &&
                    (cur_y >= eff_y0) && (cur_y <= eff_y1);

    // ------------------------------------------------------------------
    // Stage 1: expand RGB565 to 8 bits per channel and register
    // ------------------------------------------------------------------
    logic [7:0]  r8, g8, b8;
    logic        s1_vs, s1_hs, s1_de, s1_roi;
    logic [15:0] s1_rgb;
    logic [7:0]  s1_r8, s1_g8, s1_b8, s1_thresh;
    mode_e       s1_mode;

    assign r8 = {pre_rgb[15:11], pre_rgb[15:13]};
    assign g8 = {pre_rgb[10:5],  pre_rgb[10:9]};
    assign b8 = {pre_rgb[4:0],   pre_rgb[4:2]};

    // Stage 1 register; mode/thresh ride with the pixel across frame edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so in-flight pixels vanish on reset.
            s1_vs     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_de     <= 1'b0;
            s1_roi    <= 1'b0;
            s1_rgb    <= '0;
            s1_r8     <= '0;
            s1_g8     <= '0;
            s1_b8     <= '0;
            s1_thresh <= '0;
            s1_mode   <= MODE_BYPASS;
        end else begin
            s1_vs     <= pre_frame_vsync;
            s1_hs     <= pre_frame_hsync;
            s1_de     <= pre_frame_de;
            s1_roi    <= in_roi;
            s1_rgb    <= pre_rgb;
            s1_r8     <= r8;
            s1_g8     <= g8;
            s1_b8     <= b8;
            s1_thresh <= eff_thresh;
            s1_mode   <= eff_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: luma multiply-accumulate and blue-plate test
    // ------------------------------------------------------------------
    logic [17:0] luma_sum;
    logic        blue_hit;
    logic        s2_vs, s2_hs, s2_de, s2_roi, s2_blue;
    logic [15:0] s2_rgb;
    logic [7:0]  s2_y, s2_thresh;
    mode_e       s2_mode;

    // Coefficients sum to 256, so the top byte after >>8 never overflows.
    assign luma_sum = 18'd77  * 18'(s1_r8) +
                      18'd150 * 18'(s1_g8) +
                      18'd29  * 18'(s1_b8);
    assign blue_hit = (s1_b8 > s1_r8) && (s1_b8 > s1_g8) && (s1_b8 >= s1_thresh);

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_vs     <= 1'b0;
            s2_hs     <= 1'b0;
            s2_de     <= 1'b0;
            s2_roi    <= 1'b0;
            s2_blue   <= 1'b0;
            s2_rgb    <= '0;
            s2_y      <= '0;
            s2_thresh <= '0;
            s2_mode   <= MODE_BYPASS;
        end else begin
            s2_vs     <= s1_vs;
            s2_hs     <= s1_hs;
            s2_de     <= s1_de;
            s2_roi    <= s1_roi;
            s2_blue   <= blue_hit;
            s2_rgb    <= s1_rgb;
            s2_y      <= 8'(luma_sum >> 8);
            s2_thresh <= s1_thresh;
            s2_mode   <= s1_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: select the output pixel
    // ------------------------------------------------------------------
    logic [15:0] proc_rgb;
    logic        hit;

    // Output mux: mode result inside the ROI, input pixel outside, 0 in blanking
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        proc_rgb = s2_rgb;
        case (s2_mode)
            MODE_GRAY:   proc_rgb = {s2_y[7:3], s2_y[7:2], s2_y[7:3]};
            MODE_BINARY: proc_rgb = (s2_y >= s2_thresh) ? 16'hFFFF : 16'h0000;
            MODE_BLUE:   proc_rgb = s2_blue ? 16'hFFFF : 16'h0000;
            default:     proc_rgb = s2_rgb;
        endcase
        if (!s2_roi)
            proc_rgb = s2_rgb;
        if (!s2_de)
            proc_rgb = '0;
    end

    assign hit = s2_de && s2_roi &&
                 (s2_mode == MODE_BINARY || s2_mode == MODE_BLUE) &&
                 (proc_rgb == 16'hFFFF);

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            post_rgb         <= '0;
        end else begin
            post_frame_vsync <= s2_vs;
            post_frame_hsync <= s2_hs;
            post_frame_de    <= s2_de;
            post_rgb         <= proc_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Per-frame hit counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hit_acc;

    // Publish the running count at each frame start and restart it; a hit in
    // that very cycle (and any old-frame pixel still in flight) goes to the new frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_acc    <= '0;
            hit_count  <= '0;
            hits_valid <= 1'b0;
        end else begin
            hits_valid <= vs_rise;
            if (vs_rise) begin
                hit_count <= hit_acc;
                hit_acc   <= hit ? CNT_W'(1) : '0;
            end else if (hit && hit_acc != CNT_MAX) begin
                hit_acc <= hit_acc + CNT_W'(1);
            end
        end
    end

endmodule
